line_fill_reader: RTL
=====================

LINE_FILL_READER -- requirements
Module: line_fill_reader

Interface
REQ-001 Parameter: ARCACHE_VALUE, default 4'b0011, AXI read cache attribute driven on m_arcache.
REQ-002 Parameter: BEATS, default CACHE_LINE_BITS / AXI_DATA_WIDTH, AXI data beats per cache line; SHALL be a power of two ≥ 2.
REQ-003 Port: clk, input, 1, single clock; all logic is rising-edge.
REQ-004 Port: reset, input, 1, synchronous, active-low reset.
REQ-005 Port: fill_req_valid, input, 1, line-fill request present.
REQ-006 Port: fill_req_ready, output, 1, block accepts the request this cycle.
REQ-007 Port: fill_req_addr, input, cache_line_index_t, line address.
REQ-008 Port: fill_req_id, input, l1_miss_entry_idx_t, requester tag, returned unchanged.
REQ-009 Port: fill_rsp_valid, output, 1, assembled line available.
REQ-010 Port: fill_rsp_ready, input, 1, consumer accepts the line.
REQ-011 Port: fill_rsp_addr / fill_rsp_id, output, cache_line_index_t / l1_miss_entry_idx_t, captured request fields.
REQ-012 Port: fill_rsp_data, output, cache_line_data_t, assembled line.
REQ-013 Port: axi_bus, axi4_interface.master, read channels only.

Function
REQ-014 The block SHALL implement the FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
REQ-015 In IDLE, fill_req_ready=1; on valid&ready, the block SHALL capture addr and id, clear the beat counter, and enter ADDR.
REQ-016 In ADDR, the block SHALL drive m_arvalid=1, m_araddr={addr, CACHE_LINE_OFFSET_WIDTH'0}, m_arlen=BEATS-1, m_arsize=$clog2(AXI_DATA_WIDTH/8), m_arburst=AXI_BURST_INCR, and m_arcache=ARCACHE_VALUE.
REQ-017 The AR fields SHALL stay stable until s_arready; on m_arvalid&s_arready, the FSM SHALL enter DATA.
REQ-018 In DATA, m_rready=1; each s_rvalid cycle SHALL store s_rdata beat k at line bits [CACHE_LINE_BITS-1-k*AXI_DATA_WIDTH -: AXI_DATA_WIDTH], so word 0 is at the MSB, and SHALL increment k.
REQ-019 On the beat with k==BEATS-1, the FSM SHALL enter RESP; beats arriving outside DATA are a protocol violation (assertion).
REQ-020 In RESP, fill_rsp_valid=1 and data/addr/id SHALL be stable; on fill_rsp_ready, the FSM SHALL return to IDLE. Back-pressure SHALL hold RESP indefinitely.
REQ-021 fill_req_ready SHALL be 0 outside IDLE; at most one fill is outstanding.
REQ-022 Minimum latency: accept (cycle 0) -> AR (cycle 1) -> first beat no earlier than cycle 2 -> fill_rsp_valid the cycle after the last beat.
REQ-023 The write channels SHALL be tied off: m_awvalid=0, m_wvalid=0, m_bready=0; other AW/W fields SHALL be 0.
REQ-024 The beat counter SHALL be $clog2(BEATS) bits and SHALL wrap to 0 after the last beat.

Reset
REQ-025 When reset==0 at a clock edge, the FSM SHALL go to IDLE and the counter to 0. In the same cycle, m_arvalid, m_rready, fill_rsp_valid, and perf outputs SHALL be 0 and fill_req_ready=1.
REQ-026 Reset mid-burst SHALL abandon the fill with no response; the line data register is not reset.

Configuration
REQ-027 Macro LINE_FILL_PERF_EN: when defined, the block SHALL add output perf_events[1:0]. Bit 0 pulses for one cycle per accepted request. Bit 1 is high each DATA cycle with s_rvalid=0.
REQ-028 Without LINE_FILL_PERF_EN, the port and its counters SHALL be absent.

Structure
REQ-029 The FSM state enum (line_fill_state_t) SHALL live in the shared defines. BEATS SHALL derive from existing CACHE_LINE_BITS and AXI_DATA_WIDTH; no new widths.
REQ-030 The design SHALL be a single module; no sub-module.

Verification (AXI_DATA_WIDTH=32, BEATS=16)
REQ-031 Scenario: request addr=0x0400_0000>>6, id=2, s_arready immediate, 16 back-to-back beats 0x0..0xF -> m_araddr=0x0400_0000, m_arlen=15; fill_rsp_data[511:480]=0x0, [31:0]=0xF; id=2; rsp_valid 18 cycles after accept.
REQ-032 Scenario: hold s_arready=0 for 5 cycles -> m_arvalid and m_araddr stable throughout; no m_rready until after the AR handshake.
REQ-033 Scenario: insert rvalid gaps (beats on alternate cycles) -> data is correct; with LINE_FILL_PERF_EN, perf_events[1] counts 15 stall cycles.
REQ-034 Scenario: hold fill_rsp_ready=0 for 10 cycles with a second request pending -> fill_rsp stable, fill_req_ready=0; the second request is accepted the cycle after the handshake.
REQ-035 Scenario: drive reset=0 after beat 7 -> next cycle IDLE, fill_req_ready=1, m_rready=0, no fill_rsp_valid; a new request then completes normally.
REQ-036 Scenario: throughout all runs -> m_awvalid, m_wvalid, and m_bready are never 1.

Source files
------------

// File: rtl/line_fill_reader_pkg.sv
// Shared definitions for the line-fill reader: cache-line geometry, AXI
// widths, request/response field types and the fill FSM state encoding.
package line_fill_reader_pkg;

   localparam int AXI_ADDR_WIDTH          = 32;
   localparam int AXI_DATA_WIDTH          = 32;
   localparam int CACHE_LINE_BITS         = 512;
   localparam int CACHE_LINE_OFFSET_WIDTH = $clog2(CACHE_LINE_BITS / 8);
   localparam int L1_MISS_ENTRIES         = 8;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef logic [AXI_ADDR_WIDTH-CACHE_LINE_OFFSET_WIDTH-1:0] cache_line_index_t;
   typedef logic [$clog2(L1_MISS_ENTRIES)-1:0]                l1_miss_entry_idx_t;
   typedef logic [CACHE_LINE_BITS-1:0]                        cache_line_data_t;

   // One fill at a time walks through these four phases.
   typedef enum logic [1:0] {
      LF_IDLE,
      LF_ADDR,
      LF_DATA,
      LF_RESP
   } line_fill_state_t;

endpackage

// File: rtl/line_fill_reader_if.sv
// AXI4 bus bundle. Signals prefixed m_ are driven by the master, s_ by the
// slave. The line-fill reader uses the read channels and ties off the rest.
interface axi4_interface;
   import line_fill_reader_pkg::*;

   // Read address channel
   logic [AXI_ADDR_WIDTH-1:0]   m_araddr;
   logic [7:0]                  m_arlen;
   logic [2:0]                  m_arsize;
   logic [1:0]                  m_arburst;
   logic [3:0]                  m_arcache;
   logic                        m_arvalid;
   logic                        s_arready;

   // Read data channel
   logic [AXI_DATA_WIDTH-1:0]   s_rdata;
   logic [1:0]                  s_rresp;
   logic                        s_rlast;
   logic                        s_rvalid;
   logic                        m_rready;

   // Write address channel
   logic [AXI_ADDR_WIDTH-1:0]   m_awaddr;
   logic [7:0]                  m_awlen;
   logic [2:0]                  m_awsize;
   logic [1:0]                  m_awburst;
   logic [3:0]                  m_awcache;
   logic                        m_awvalid;
   logic                        s_awready;

   // Write data channel
   logic [AXI_DATA_WIDTH-1:0]   m_wdata;
   logic [AXI_DATA_WIDTH/8-1:0] m_wstrb;
   logic                        m_wlast;
   logic                        m_wvalid;
   logic                        s_wready;

   // Write response channel
   logic [1:0]                  s_bresp;
   logic                        s_bvalid;
   logic                        m_bready;

   modport master (
      output m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_arvalid,
      input  s_arready,
      input  s_rdata, s_rresp, s_rlast, s_rvalid,
      output m_rready,
      output m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache, m_awvalid,
      input  s_awready,
      output m_wdata, m_wstrb, m_wlast, m_wvalid,
      input  s_wready,
      input  s_bresp, s_bvalid,
      output m_bready
   );

   modport slave (
      input  m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_arvalid,
      output s_arready,
      output s_rdata, s_rresp, s_rlast, s_rvalid,
      input  m_rready,
      input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache, m_awvalid,
      output s_awready,
      input  m_wdata, m_wstrb, m_wlast, m_wvalid,
      output s_wready,
      output s_bresp, s_bvalid,
      input  m_bready
   );

endinterface

// File: rtl/line_fill_reader.sv
// Line-fill reader: accepts one cache-line fill request, issues a single
// INCR AXI read burst for the whole line, packs the beats (first beat at the
// MSB end of the line) and presents the assembled line until it is taken.
// Optional build macro LINE_FILL_PERF_EN adds the perf_events[1:0] output
// (bit 0: request accepted, bit 1: data phase cycle without a beat).
module line_fill_reader
   import line_fill_reader_pkg::*;
#(
   parameter logic [3:0] ARCACHE_VALUE = 4'b0011,
   // Must be a power of two, at least 2.
   parameter int         BEATS         = CACHE_LINE_BITS / AXI_DATA_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fill_req_valid,
   output logic               fill_req_ready,
   input  cache_line_index_t  fill_req_addr,
   input  l1_miss_entry_idx_t fill_req_id,
   output logic               fill_rsp_valid,
   input  logic               fill_rsp_ready,
   output cache_line_index_t  fill_rsp_addr,
   output l1_miss_entry_idx_t fill_rsp_id,
   output cache_line_data_t   fill_rsp_data,
   axi4_interface.master      axi_bus
`ifdef LINE_FILL_PERF_EN
   ,
   output logic [1:0]         perf_events
`endif
);

   localparam int                BEAT_W    = $clog2(BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [7:0]        AR_LEN    = 8'(BEATS - 1);
   localparam logic [2:0]        AR_SIZE   = 3'($clog2(AXI_DATA_WIDTH / 8));

   line_fill_state_t   state_q, state_d;
   cache_line_index_t  addr_q, addr_d;
   l1_miss_entry_idx_t id_q, id_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic               beat_we;
   logic               ar_valid;
   logic               r_ready;

   // Word k of the burst lives in element BEATS-1-k, so beat 0 lands at the MSB.
   logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] line_q;

   // Next-state, request capture and handshake decode for the fill sequence.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
      state_d        = state_q;
      addr_d         = addr_q;
      id_d           = id_q;
      beat_d         = beat_q;
      beat_we        = 1'b0;
      fill_req_ready = 1'b0;
      fill_rsp_valid = 1'b0;
      ar_valid       = 1'b0;
      r_ready        = 1'b0;

      case (state_q)
         LF_IDLE: begin
            fill_req_ready = 1'b1;
            if (fill_req_valid) begin
               addr_d  = fill_req_addr;
               id_d    = fill_req_id;
               beat_d  = '0;
               state_d = LF_ADDR;
            end
         end
         LF_ADDR: begin
            ar_valid = 1'b1;
            if (axi_bus.s_arready) begin
               state_d = LF_DATA;
            end
         end
         LF_DATA: begin
            r_ready = 1'b1;
            if (axi_bus.s_rvalid) begin
               beat_we = 1'b1;
               beat_d  = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  state_d = LF_RESP;
               end
            end
         end
         LF_RESP: begin
            fill_rsp_valid = 1'b1;
            if (fill_rsp_ready) begin
               state_d = LF_IDLE;
            end
         end
         default: state_d = LF_IDLE;
      endcase

      // While reset is asserted the block looks idle on its outputs at once.
      if (!reset) begin
         beat_we        = 1'b0;
         fill_req_ready = 1'b1;
         fill_rsp_valid = 1'b0;
         ar_valid       = 1'b0;
         r_ready        = 1'b0;
      end
   end

   // Control state: FSM, captured request fields and beat counter.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!reset) begin
         state_q <= LF_IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         beat_q  <= beat_d;
      end
   end

   // Line assembly: each accepted beat is written into its word slot.
   always_ff @(posedge clk) begin
      // NOTE: the line buffer has no reset; it is only read after a full burst has overwritten every word.
      if (beat_we) begin
         line_q[LAST_BEAT - beat_q] <= axi_bus.s_rdata;
      end
   end

   assign fill_rsp_addr = addr_q;
   assign fill_rsp_id   = id_q;
   assign fill_rsp_data = line_q;

   // Read address and data channels.
   assign axi_bus.m_arvalid = ar_valid;
   assign axi_bus.m_araddr  = {addr_q, {CACHE_LINE_OFFSET_WIDTH{1'b0}}};
   assign axi_bus.m_arlen   = AR_LEN;
   assign axi_bus.m_arsize  = AR_SIZE;
   assign axi_bus.m_arburst = AXI_BURST_INCR;
   assign axi_bus.m_arcache = ARCACHE_VALUE;
   assign axi_bus.m_rready  = r_ready;

   // This block never writes; the write channels are held quiet.
   assign axi_bus.m_awaddr  = '0;
   assign axi_bus.m_awlen   = '0;
   assign axi_bus.m_awsize  = '0;
   assign axi_bus.m_awburst = '0;
   assign axi_bus.m_awcache = '0;
   assign axi_bus.m_awvalid = 1'b0;
   assign axi_bus.m_wdata   = '0;
   assign axi_bus.m_wstrb   = '0;
   assign axi_bus.m_wlast   = 1'b0;
   assign axi_bus.m_wvalid  = 1'b0;
   assign axi_bus.m_bready  = 1'b0;

   // Slave-side fields this reader has no use for.
   logic unused_axi;
   assign unused_axi = ^{axi_bus.s_rresp, axi_bus.s_rlast, axi_bus.s_awready,
                         axi_bus.s_wready, axi_bus.s_bresp, axi_bus.s_bvalid};

`ifdef LINE_FILL_PERF_EN
   assign perf_events[0] = reset & fill_req_valid & fill_req_ready;
   assign perf_events[1] = reset & (state_q == LF_DATA) & ~axi_bus.s_rvalid;
`endif

   // A slave may only present read data while the burst is in its data phase.
   a_rvalid_only_in_data: assert property (
      @(posedge clk) disable iff (!reset) axi_bus.s_rvalid |-> (state_q == LF_DATA)
   );

endmodule
